// File: rtl/pull_line_pkg.sv
// Shared definitions for the wired-OR pull line transmitter and receiver.
package pull_line_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b0;
  localparam logic START_LEVEL = 1'b1;

endpackage

// File: rtl/line_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module line_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pull_line_rx.sv
// Receiver for the wired-OR pull line: start detect, mid-bit sampling,
// valid/ready holding register with framing-error and overrun pulses.
module pull_line_rx
  import pull_line_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 line,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);

  logic line_s;

  line_sync #(.RESET_VAL(IDLE_LEVEL)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (line),
    .q     (line_s)
  );

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 armed_q, armed_d;
  logic                 tick;
  logic                 good;
  logic                 bad;

  assign tick = (timer_q == '0);
  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      armed_q <= armed_d;
    end
  end

  // armed_q records that the line has been seen idle since the last framing
  // error, so a line stuck at the start level cannot retrigger reception.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    armed_d = armed_q | (line_s == IDLE_LEVEL);
    good    = 1'b0;
    bad     = 1'b0;

    if (state_q != IDLE && !tick) begin
      timer_d = timer_q - 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (armed_q && line_s == START_LEVEL) begin
          state_d = START;
          timer_d = HALF_LOAD;
          cnt_d   = '0;
        end
      end
      START: begin
        if (tick) begin
          if (line_s == START_LEVEL) begin
            state_d = DATA;
            timer_d = FULL_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d = {line_s, shreg_q[DATA_BITS-1:1]};
          timer_d = FULL_LOAD;
          if (cnt_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          if (line_s == IDLE_LEVEL) begin
            good = 1'b1;
          end else begin
            bad     = 1'b1;
            armed_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad;
      overrun   <= good && rx_valid && !rx_ready;
      if (good && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
